// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package serial_add_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell, purely combinational.
module serial_add_ctrl_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: feeds one full-adder cell LSB first, one bit per cycle,
// with valid/ready handshakes on operands and result.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic               msb_cin_q, msb_cin_d;
    logic               fa_sum, fa_cout;

    serial_add_ctrl_fa u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = op_a;
                    b_sh_d  = op_b;
                    carry_d = cin;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                // carry_q here is the carry into the MSB; keep it for overflow detection
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    msb_cin_d = carry_q;
                    state_d   = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign sum       = sum_sh_q;
    assign cout      = carry_q;
    assign ovf       = msb_cin_q ^ carry_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial multi-bit adder controller that drives one instance of the team's one-bit full-adder cell. Operands are accepted through a valid/ready handshake, and the block presents one bit pair plus the registered carry to the cell each cycle. It shifts the cell's sum back into a result register, holds the carry between cycles, and returns the WIDTH-bit sum, carry-out and signed overflow through an output valid/ready handshake. It sits directly upstream and downstream of the full-adder cell, trading area for WIDTH cycles of latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand transfer request.
in_ready  out  1  block can accept operands.
op_a  in  WIDTH  addend A, unsigned or two's complement.
op_b  in  WIDTH  addend B.
cin  in  1  carry-in for bit 0.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts result.
sum  out  WIDTH  result bits.
cout  out  1  carry out of bit WIDTH-1.
ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
busy  out  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. Reset is fixed; no synchronous reset path.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, count=0, carry=0, operand shift registers=0.
- in_ready is asserted only in IDLE. out_valid is asserted only in DONE. Both are decoded from registered state, so neither has a combinational path from an input.
- FSM states:
  - IDLE: on in_valid=1, load a_sh←op_a, b_sh←op_b, carry←cin, count←0; go to SHIFT. in_valid=0 holds IDLE.
  - SHIFT: the cell sees a=a_sh[0], b=b_sh[0], cin=carry. Each edge:
    - sum_sh←{fa_sum, sum_sh[WIDTH-1:1]}
    - a_sh, b_sh shift right by 1 with zero fill
    - carry←fa_cout; count←count+1
    - at count==WIDTH-1, msb_cin←carry is captured, then go to DONE.
  - DONE: sum=sum_sh, cout=carry, ovf=msb_cin^carry, all stable. out_ready=1 → IDLE. out_ready=0 → hold all outputs indefinitely.
- Latency: if operands are accepted at edge k, out_valid rises after edge k+WIDTH. Minimum initiation interval is WIDTH+2 cycles; there is no accept in the same cycle as result release.
- Handshake rules:
  - in_valid, op_a, op_b and cin are ignored outside IDLE.
  - Operands are sampled only on the accepting edge.
  - Upstream may change or drop operands after acceptance with no effect.
- Wrap-around:
  - The carry out of the MSB goes to cout only; sum wraps modulo 2^WIDTH.
  - count never exceeds WIDTH-1.
- Simultaneous events: rst dominates everything. In DONE, out_ready with in_valid completes the output transfer only; the new operands wait for in_ready next cycle.
- Reset mid-operation: an in-flight sum is discarded and all outputs return to reset values asynchronously. in_ready is high from the first edge after rst deasserts.
- sum, cout and ovf keep their last value after returning to IDLE. They are valid only while out_valid=1.

Decomposition:
- Shared package: the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH. 2'd3 is illegal and recovers to IDLE.
- One sub-module: the existing one-bit full-adder cell, instantiated once and combinational.
- The controller holds all sequential logic: the FSM, the counter, the three shift registers and the carry/msb_cin flops.

Test Plan:
1. WIDTH=8, op_a=0xFF, op_b=0x01, cin=0 -> after 8 shift cycles out_valid=1, sum=0x00, cout=1, ovf=0.
2. op_a=0x7F, op_b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Also op_a=0x80, op_b=0x80 -> sum=0x00, cout=1, ovf=1.
3. op_a=0xA5, op_b=0x5A, cin=1 -> sum=0x00, cout=1, ovf=0. Bench checks out_valid rises exactly 8 edges after acceptance.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout, ovf and out_valid stay stable and in_ready stays 0. in_valid pulses with op_a=0x11 during SHIFT/DONE are ignored. Release out_ready -> IDLE next edge, in_ready=1.
5. Assert rst while count=3 in SHIFT -> out_valid, sum, cout and ovf go to 0 immediately and busy=0. After release, a new 0x03+0x04 transfer yields sum=0x07.
6. Back-to-back: random 200 operand pairs with random in_valid/out_ready gaps -> every sum, cout and ovf matches a reference model; no result is lost or duplicated.
